// File: rtl/g2b_pkg.sv
// Shared types and helpers for the iterative Gray-to-binary decoder.
`timescale 1ns/1ps
package g2b_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} g2b_state_t;

  // Width of the chunk index counter; never narrower than one bit.
  function automatic int unsigned g2b_idx_width(input int unsigned n, input int unsigned bpc);
    int unsigned w;
    w = $clog2(n / bpc);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/g2b_chunk.sv
// Combinational decode of one BPC-bit Gray chunk, prefix XOR running LSB upward.
`timescale 1ns/1ps
module g2b_chunk #(
  parameter int unsigned BPC = 2
) (
  input  logic [BPC-1:0] i_gray,
  input  logic           i_carry,
  output logic [BPC-1:0] o_bin,
  output logic           o_carry
);

  logic w_acc;

  always_comb begin
    o_bin = '0;
    w_acc = i_carry;
    for (int j = 0; j < BPC; j++) begin
      w_acc    = w_acc ^ i_gray[j];
      o_bin[j] = w_acc;
    end
    o_carry = o_bin[BPC-1];
  end

endmodule

// File: rtl/g2b_iter.sv
// Iterative Gray-to-binary decoder: BPC bits per clock, valid/ready on both sides.
`timescale 1ns/1ps
module g2b_iter
  import g2b_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned BPC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] gray_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] bin_out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned NCHUNK = N / BPC;
  localparam int unsigned KW     = g2b_idx_width(N, BPC);

  if (N < 2 || BPC < 1 || BPC > N || (N % BPC) != 0) begin : g_bad_params
    $error("g2b_iter: N must be >= 2 and a multiple of BPC, with 1 <= BPC <= N");
  end

  g2b_state_t    r_state;
  logic [N-1:0]  r_gray;
  logic [N-1:0]  r_bin;
  logic          r_carry;
  logic [KW-1:0] r_k;
  logic          r_in_ready;
  logic          r_out_valid;

  logic [31:0]    w_base;
  logic [BPC-1:0] w_gray_chunk;
  logic [BPC-1:0] w_bin_chunk;
  logic           w_carry;
  logic           w_last;
  logic [N-1:0]   w_mask;
  logic [N-1:0]   w_ins;

  // Shifts instead of variable part-selects keep index widths clean.
  assign w_base       = 32'(r_k) * BPC;
  assign w_gray_chunk = BPC'(r_gray >> w_base);
  assign w_mask       = N'({BPC{1'b1}}) << w_base;
  assign w_ins        = N'(w_bin_chunk) << w_base;
  assign w_last       = (r_k == KW'(NCHUNK - 1));

  g2b_chunk #(
    .BPC (BPC)
  ) u_chunk (
    .i_gray  (w_gray_chunk),
    .i_carry (r_carry),
    .o_bin   (w_bin_chunk),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gray      <= '0;
      r_bin       <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_gray     <= gray_in;
            r_k        <= '0;
            r_carry    <= 1'b0;
            r_state    <= BUSY;
            r_in_ready <= 1'b0;
          end
        end
        BUSY: begin
          // Undecoded bits keep their previous value until their chunk arrives.
          r_bin   <= (r_bin & ~w_mask) | w_ins;
          r_carry <= w_carry;
          if (w_last) begin
            r_k         <= '0;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign bin_out   = r_bin;

endmodule

// File: tb/tb_g2b_iter.sv
// Scoreboard bench for g2b_iter: directed, random and exhaustive round-trip runs.
`timescale 1ns/1ps
module tb_g2b_iter;

  localparam int NB = 4;  // N/BPC of the main instance (8/2)

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gray_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] bin_out;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random
  int done_cnt = 0;
  logic prev_v = 1'b0;

  typedef struct {
    logic [7:0] bin;
    int         acc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  g2b_iter #(
    .N   (8),
    .BPC (2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Reference: binary bit i is the XOR of Gray bits 0..i.
  function automatic logic [7:0] ref_dec(input logic [7:0] g);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      int m;
      m    = (2 << i) - 1;
      b[i] = ^(int'(g) & m);
    end
    return b;
  endfunction

  function automatic logic [7:0] b2g(input logic [7:0] b);
    return b ^ (b << 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready <= 1'b0;
    else if (rdy_mode == 1) out_ready <= 1'b1;
    else                    out_ready <= 1'($urandom_range(0, 1));
  end

  // Monitor: compares every valid cycle against the head of the scoreboard.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_output", {31'd0, out_valid}, 32'd0);
      end else begin
        if (!prev_v) chk("latency", 32'(cyc), 32'(q[0].acc + NB));
        chk("bin_out", {24'd0, bin_out}, {24'd0, q[0].bin});
        chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
        if (out_ready) void'(q.pop_front());
      end
    end
    prev_v <= out_valid;
  end

  task automatic send(input logic [7:0] g, input logic [7:0] e, input bit push);
    int n;
    @(negedge clk);
    gray_in  = g;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("accept");
      in_valid = 1'b0;
      return;
    end
    if (push) q.push_back('{bin: e, acc: cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) fail_now("drain");
  endtask

  initial begin
    int n;
    logic [7:0] g;
    rst      = 1'b1;
    in_valid = 1'b0;
    gray_in  = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_bin_out", {24'd0, bin_out}, 32'd0);
    rst = 1'b0;

    send(8'h03, 8'h01, 1'b1);
    send(8'hFF, 8'h55, 1'b1);
    send(8'h80, 8'h80, 1'b1);
    send(8'h00, 8'h00, 1'b1);
    drain();

    // Backpressure: output held, new word refused.
    rdy_mode = 0;
    send(8'h03, 8'h01, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("bp_out_valid");
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      gray_in  = 8'hAA;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    rdy_mode = 1;
    n = 0;
    while (out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_queue_empty", 32'(q.size()), 32'd0);

    // Reset two cycles into a word: it must vanish.
    send(8'hFF, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_bin_out", {24'd0, bin_out}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) @(negedge clk);

    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      g = 8'($urandom);
      send(g, ref_dec(g), 1'b1);
    end
    drain();
    rdy_mode = 1;

    n = 0;
    while (done_cnt < 4 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < 4) fail_now("roundtrip_done");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Exhaustive round-trip at BPC = 1, 2, 4, 8.
  for (genvar gi = 0; gi < 4; gi++) begin : g_x
    localparam int unsigned XB  = 1 << gi;
    localparam int          XNB = 8 / XB;
    logic       x_rst;
    logic       x_iv;
    logic       x_ir;
    logic       x_ov;
    logic [7:0] x_g;
    logic [7:0] x_b;

    g2b_iter #(
      .N   (8),
      .BPC (XB)
    ) u_x (
      .clk       (clk),
      .rst       (x_rst),
      .gray_in   (x_g),
      .in_valid  (x_iv),
      .in_ready  (x_ir),
      .bin_out   (x_b),
      .out_valid (x_ov),
      .out_ready (1'b1)
    );

    initial begin
      int lat;
      logic [7:0] bv;
      x_rst = 1'b1;
      x_iv  = 1'b0;
      x_g   = '0;
      repeat (2) @(negedge clk);
      x_rst = 1'b0;
      for (int v = 0; v < 256; v++) begin
        bv   = 8'(v);
        x_g  = b2g(bv);
        x_iv = 1'b1;
        lat  = 0;
        chk($sformatf("rt_bpc%0d_ready", XB), {31'd0, x_ir}, 32'd1);
        while (!x_ov && lat < 40) begin
          @(negedge clk);
          x_iv = 1'b0;
          lat++;
        end
        if (!x_ov) begin
          fail_now($sformatf("rt_bpc%0d_valid", XB));
        end else begin
          chk($sformatf("rt_bpc%0d_latency", XB), 32'(lat - 1), 32'(XNB));
          chk($sformatf("rt_bpc%0d_value", XB), {24'd0, x_b}, {24'd0, bv});
        end
        @(negedge clk);
      end
      done_cnt++;
    end
  end

endmodule

// File: doc/g2b_iter.md
Name: g2b_iter

Overview:
- Iterative Gray-to-binary decoder; the inverse of the team's `b2g` encoder.
- Code convention shared with the encoder: g[0]=b[0], g[i]=b[i]^b[i-1]. Decoding is therefore b[0]=g[0], b[i]=g[i]^b[i-1], a prefix XOR running LSB upward.
- Decodes BPC bits per clock, carrying the running XOR between cycles.
- Valid/ready handshake on both sides; sits between a Gray-coded source (counter or pointer path) and binary consumers.

Parameters:
- N, 8, word width in bits; N >= 2.
- BPC, 2, bits decoded per cycle; 1 <= BPC <= N and N % BPC == 0, enforced by an elaboration-time assertion.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- gray_in, input, N, Gray-coded word.
- in_valid, input, 1, gray_in is valid.
- in_ready, output, 1, block accepts a word this cycle.
- bin_out, output, N, decoded binary word.
- out_valid, output, 1, bin_out holds a completed result.
- out_ready, input, 1, consumer takes bin_out this cycle.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, in_ready=1, out_valid=0, bin_out=0, internal gray register, carry and chunk index all 0.
- Reset mid-operation aborts the word in progress; no output is produced for it.
- State machine states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE); out_valid = (state==DONE). Both are registered-state decodes with no combinational path from the inputs.
- IDLE:
  - Condition in_valid && in_ready at an edge: capture gray_in, set chunk index k=0 and carry=0, go to BUSY.
  - Otherwise hold.
- BUSY, each edge:
  - For j in 0..BPC-1, with bit index p=k*BPC+j: b[p] = g[p] ^ (j==0 ? carry : b[p-1]).
  - Write these bits into bin_out[p].
  - carry <= b[k*BPC+BPC-1]; k <= k+1.
  - On the edge processing the last chunk (k==N/BPC-1), go to DONE.
- Latency: out_valid rises exactly N/BPC clock edges after the accepting edge. Defaults give 4.
- DONE:
  - bin_out holds stable while out_valid=1 and out_ready=0.
  - On the edge with out_ready=1, go to IDLE; in_ready is high the following cycle.
- Throughput: one word per N/BPC+2 cycles minimum. There is no overlap between consecutive words.
- gray_in and in_valid are ignored outside IDLE.
- out_ready is ignored outside DONE.
- bin_out bits not yet decoded during BUSY hold their previous value. Consumers sample only while out_valid=1.
- Simultaneous in_valid and out_ready cannot conflict, because the two are qualified by mutually exclusive states.
- BPC==N decodes the whole word in a single BUSY cycle.

Decomposition:
- Package g2b_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} g2b_state_t;
  - a helper function giving the chunk-index width, $clog2(N/BPC) with a minimum of 1.
- Sub-module g2b_chunk (parameter BPC), purely combinational:
  - inputs: gray chunk, carry_in.
  - outputs: binary chunk, carry_out (MSB of the binary chunk).
  - g2b_iter instantiates it once; g2b_iter owns the FSM, the index counter and the registers.

Test Plan:
- Reset, then gray_in=8'h03 with in_valid=1 → accepted on the first edge; out_valid=1 exactly 4 cycles later with bin_out=8'h01.
- gray_in=8'hFF → bin_out=8'h55. gray_in=8'h80 → bin_out=8'h80. gray_in=8'h00 → bin_out=8'h00.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - Required: bin_out stable, in_ready=0 throughout, and a new in_valid word is not accepted.
  - Release out_ready → IDLE next cycle and in_ready=1.
- Reset mid-operation: assert rst two cycles after accepting 8'hFF.
  - Required: next cycle out_valid=0, bin_out=0, in_ready=1, and no output ever appears for that word.
- Exhaustive round-trip with N=8 at BPC=1, 2, 4 and 8: feed all 256 codes produced by b2g from binary 0..255.
  - Required: bin_out equals the original binary for every code, and latency equals N/BPC in each configuration.
